// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin arbiter that grants one of four requesters an
// exclusive time slot of a programmed length, then pulses completion (done)
// or early termination (aborted) before returning to idle.
module timer_arbiter #(
  parameter int CW = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enable,
  input  logic [3:0]      req,
  input  logic [4*CW-1:0] dur,
  output logic [3:0]      grant,
  output logic [1:0]      active_id,
  output logic            busy,
  output logic [CW-1:0]   elapsed,
  output logic [3:0]      done,
  output logic            aborted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      last_id;
  logic [1:0]      winner;
  logic            start;
  logic [CW-1:0]   dur_q;
  logic [CW-1:0]   dur_sel;
  logic [CW-1:0]   last_cnt;

  // First set request bit searching last+1, last+2, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                         input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  // Arbitration winner, selected duration and the final elapsed value of the slot.
  always_comb begin
    winner   = rr_pick(last_id, req);
    start    = (state == S_IDLE) && enable && (|req);
    dur_sel  = '0;
    for (int i = 0; i < 4; i++) begin
      if (winner == 2'(i)) dur_sel = dur[i*CW +: CW];
    end
    // A programmed length of zero still yields a one-cycle slot.
    last_cnt = (dur_q == '0) ? '0 : dur_q - 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a dropped request beats completion on the final cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (!req[active_id])          state_nxt = S_ABORT;
        else if (elapsed == last_cnt) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Slot bookkeeping: granted id, round-robin pointer and elapsed counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_id <= 2'd0;
      last_id   <= 2'd3;
      elapsed   <= '0;
    end else begin
      if (start) begin
        active_id <= winner;
        last_id   <= winner;
        elapsed   <= '0;
      end else if (state == S_RUN && state_nxt == S_RUN) begin
        elapsed   <= sat_inc(elapsed);
      end else begin
        elapsed   <= '0;
      end
    end
  end

  // Duration is captured once at grant time; later changes on dur are ignored.
  always_ff @(posedge clk) begin
    if (start) dur_q <= dur_sel;
  end

  // Outputs decoded from state; active_id is held through DONE for the pulse.
  always_comb begin
    grant   = 4'b0000;
    done    = 4'b0000;
    busy    = 1'b0;
    aborted = 1'b0;
    case (state)
      S_RUN: begin
        grant = 4'b0001 << active_id;
        busy  = 1'b1;
      end
      S_DONE:  done    = 4'b0001 << active_id;
      S_ABORT: aborted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one interval counter among 4 requesters.
- Each requester asks for an exclusive time slot of a programmed length in clk cycles.
- The block grants requesters round-robin, holds the grant for the requested duration, then signals completion.
- It sits between acquisition/pulse sequencers and any shared resource that needs timed exclusive access, such as a shared output channel or trigger line.

Parameters:
- CW, 32, width of the duration and elapsed counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- enable  input  1  1 = new grants allowed; 0 = finish the current slot, then stay idle.
- req  input  4  per-requester request level; must stay high for the whole slot.
- dur  input  4*CW  packed durations; requester i uses dur[i*CW +: CW].
- grant  output  4  one-hot grant; all zero when no slot is active.
- active_id  output  2  index of the granted requester; valid while busy.
- busy  output  1  high while in RUN.
- elapsed  output  CW  cycles granted so far in the current slot.
- done  output  4  one-cycle completion pulse for the finishing requester.
- aborted  output  1  one-cycle pulse when a slot ends early.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, grant=0, active_id=0, busy=0, elapsed=0, done=0, aborted=0. The round-robin pointer last_id resets to 3, so requester 0 has first priority. Reset mid-slot drops grant immediately, with no done pulse.
- States:
  - IDLE: no grant held. Arbitrates when enable=1 and req≠0.
  - RUN: grant held, counter running.
  - DONE: one-cycle completion state.
  - ABORT: one-cycle early-termination state.
- Arbitration (IDLE):
  - Winner is the first set req bit searching last_id+1, last_id+2, … modulo 4.
  - On the clk edge where IDLE sees enable=1 and req≠0: grant[winner]=1, active_id=winner, busy=1, elapsed=0, last_id=winner, and dur[winner] is latched into dur_q. State moves to RUN.
  - Latency is 1 cycle from req sampled to grant visible.
- Duration rule:
  - Slot length L = dur_q, except dur_q=0 is treated as L=1.
  - Grant stays high for exactly L cycles.
  - elapsed counts 0,1,…,L-1 across those cycles.
  - Changes to dur after the latch are ignored.
- RUN → DONE: on the cycle where elapsed==L-1 and req[active_id]=1.
  - Next cycle: grant=0, busy=0, done[active_id]=1 for exactly 1 cycle, elapsed=0.
- RUN → ABORT: if req[active_id]=0 at any RUN cycle, including the final one, abort takes priority over completion.
  - Next cycle: grant=0, busy=0, aborted=1 for 1 cycle, no done pulse, elapsed=0.
- DONE or ABORT → IDLE unconditionally.
  - Minimum gap between two consecutive grants is 2 idle-grant cycles (DONE/ABORT plus IDLE).
- enable:
  - Sampled only in IDLE.
  - Deasserting enable during RUN does not shorten the slot.
- Requests from other requesters during RUN are ignored, not queued; they are re-evaluated in IDLE.
- The elapsed counter saturates at 2^CW-1. This is unreachable in normal use because L ≤ 2^CW-1.
- At most one bit of grant and of done is ever high; done and grant are never high in the same cycle.

Test Plan:
1. Single request, req=0001, dur0=5, enable=1 → grant=0001 one cycle after req, high for exactly 5 cycles; elapsed 0..4; done=0001 for 1 cycle; back to IDLE.
2. Zero duration, req=0100, dur2=0 → grant=0100 for exactly 1 cycle, then done=0100.
3. Round-robin fairness, req=1111 held, all dur=3 → grant order 0,1,2,3,0,…; each grant lasts 3 cycles; grant rising edges are 5 cycles apart.
4. Abort: req=0010, dur1=10, drop req1 after 4 granted cycles → grant falls the next cycle, aborted pulses once, no done; then req=0001 → requester 0 granted (pointer=1).
5. Enable and duration handling: deassert enable mid-slot with dur=6 → full 6-cycle slot completes, no further grant while enable=0 with req≠0. Separately, change dur mid-slot → slot length unaffected.
6. Reset mid-slot: assert rstn=0 at elapsed=2 → grant, busy, and elapsed go to 0 immediately (asynchronous), no done. After release with req=1111 → requester 0 granted first.
